// File: rtl/input_conditioner.sv
// Synchronizer + debouncer bank: one lane per raw input, plus a shared busy flag.
// Define INPUT_CONDITIONER_EDGE_EN to build the rise_p/fall_p pulse registers.

module input_conditioner_ch #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_cnt_nz
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_accept;

   assign w_diff   = r_sync2 ^ r_level;
   // cnt == DEB_CYCLES-1 is the same test as cnt+1 == DEB_CYCLES, without the extra carry bit
   assign w_accept = w_diff && (r_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + ONE;
         end
      end
   end

   assign o_level  = r_level;
   assign o_cnt_nz = (r_cnt != '0);

`ifdef INPUT_CONDITIONER_EDGE_EN
   logic r_rise;
   logic r_fall;

   // Pulses load on the same edge as the level, so they sit in the cycle right after the change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_accept & r_sync2;
         r_fall <= w_accept & ~r_sync2;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

module input_conditioner #(
   parameter int NCH        = 6,
   parameter int DEB_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] raw_in,
   output logic [NCH-1:0] level_out,
   output logic [NCH-1:0] rise_p,
   output logic [NCH-1:0] fall_p,
   output logic           busy
);
   logic [NCH-1:0] w_cnt_nz;
   logic           r_busy;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      input_conditioner_ch #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_raw    (raw_in[g]),
         .o_level  (level_out[g]),
         .o_rise   (rise_p[g]),
         .o_fall   (fall_p[g]),
         .o_cnt_nz (w_cnt_nz[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= 1'b0;
      else     r_busy <= |w_cnt_nz;
   end

   assign busy = r_busy;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (NCH=6, DEB_CYCLES=4): fixed vectors, corner sequences,
// and random traffic checked against a run-length model of the debounce rules.
module tb_input_conditioner;
   localparam int NCH = 6;
   localparam int DEB = 4;
`ifdef INPUT_CONDITIONER_EDGE_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [NCH-1:0] raw_in = '0;
   logic [NCH-1:0] level_out, rise_p, fall_p;
   logic           busy;

   input_conditioner #(.NCH(NCH), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .raw_in(raw_in),
      .level_out(level_out), .rise_p(rise_p), .fall_p(fall_p), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference: raw history queue (two-edge sync delay) + per-channel disagreement run length
   logic [NCH-1:0] m_hist[$];
   int             m_run[NCH];
   logic [NCH-1:0] m_lvl, m_rise, m_fall;
   logic           m_busy;

   typedef struct packed {
      logic           rst_first;
      logic [NCH-1:0] raw;
      logic [NCH-1:0] lvl;
      logic [NCH-1:0] rise;
      logic           bsy;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [NCH-1:0] raw,
                               input logic [NCH-1:0] lvl, input logic [NCH-1:0] rise,
                               input logic bsy);
      vec_t v;
      v.rst_first = r; v.raw = raw; v.lvl = lvl; v.rise = rise; v.bsy = bsy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
   endtask

   task automatic m_step(input logic [NCH-1:0] v);
      logic [NCH-1:0] s2;
      s2 = m_hist.pop_front();
      m_hist.push_back(v);
      m_busy = 1'b0;
      for (int i = 0; i < NCH; i++) if (m_run[i] != 0) m_busy = 1'b1;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < NCH; i++) begin
         if (s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_run[i]  = 0;
               m_lvl[i]  = s2[i];
               m_rise[i] = s2[i];
               m_fall[i] = ~s2[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_lvl"},  32'(level_out), 32'(0));
      chk({tag, "_rise"}, 32'(rise_p),    32'(0));
      chk({tag, "_fall"}, 32'(fall_p),    32'(0));
      chk({tag, "_busy"}, 32'(busy),      32'(0));
   endtask

   task automatic tick(input logic [NCH-1:0] v);
      raw_in = v;
      @(posedge clk);
      m_step(v);
      @(negedge clk);
      chk("level", 32'(level_out), 32'(m_lvl));
      chk("rise",  32'(rise_p),    EN ? 32'(m_rise) : 32'(0));
      chk("fall",  32'(fall_p),    EN ? 32'(m_fall) : 32'(0));
      chk("busy",  32'(busy),      32'(m_busy));
      chk("excl",  32'(rise_p & fall_p), 32'(0));
   endtask

   task automatic do_reset();
      raw_in = '0;
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [NCH-1:0] acc_lvl, acc_p, r;
      int n_r, n_f;

      #1 rst = 1'b1;
      m_reset();
      #1 chk_zero("por");

      // single channel accept, then a glitch one cycle short of the debounce length
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(k == 0, 6'b000001, (k >= 5) ? 6'b000001 : 6'b0,
                          (k == 5) ? 6'b000001 : 6'b0, (k >= 3 && k <= 5)));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(k == 0, (k < 3) ? 6'b000100 : 6'b0, 6'b0, 6'b0,
                          (k >= 3 && k <= 5)));
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_first) do_reset();
         tick(tbl[i].raw);
         chk("tbl_lvl",  32'(level_out), 32'(tbl[i].lvl));
         chk("tbl_rise", 32'(rise_p),    EN ? 32'(tbl[i].rise) : 32'(0));
         chk("tbl_fall", 32'(fall_p),    32'(0));
         chk("tbl_busy", 32'(busy),      32'(tbl[i].bsy));
      end

      // two channels rise and fall together
      do_reset();
      n_r = 0; n_f = 0;
      for (int k = 0; k < 14; k++) begin
         tick(6'b110000);
         if (rise_p == 6'b110000) n_r++;
      end
      chk("grp_lvl", 32'(level_out), 32'(6'b110000));
      for (int k = 0; k < 14; k++) begin
         tick(6'b000000);
         if (fall_p == 6'b110000) n_f++;
      end
      chk("grp_rise_cnt", 32'(n_r), EN ? 32'(1) : 32'(0));
      chk("grp_fall_cnt", 32'(n_f), EN ? 32'(1) : 32'(0));

      // reset asserted mid-count discards it; full latency counted from release
      do_reset();
      for (int k = 0; k < 3; k++) tick(6'b100000);
      @(posedge clk);
      m_step(6'b100000);
      #2 rst = 1'b1;
      m_reset();
      #1 chk_zero("async_rst");
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_zero("held_rst");
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick(6'b100000);
         chk("rst_lat", 32'(level_out[5]), 32'(k >= 6));
      end

      // bounce shorter than the window never gets through
      do_reset();
      acc_lvl = '0; acc_p = '0;
      for (int k = 0; k < 40; k++) begin
         tick(((k / 2) % 2 == 1) ? 6'b001000 : 6'b000000);
         acc_lvl |= level_out;
         acc_p   |= rise_p | fall_p;
      end
      chk("bounce_lvl", 32'(acc_lvl), 32'(0));
      chk("bounce_pls", 32'(acc_p),   32'(0));

      // random traffic with sparse bit flips so some changes survive the window
      do_reset();
      r = '0;
      for (int k = 0; k < 600; k++) begin
         for (int b = 0; b < NCH; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         tick(r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
